// File: rtl/tap_load_arbiter.sv
// tap_load_arbiter: shares the single main-RAM port between the 6502 bus and the HPS .TAP
// download stream. Optional build macro TAP_LOAD_CHECKSUM_EN adds a mod-256 checksum output.
module tap_load_arbiter #(
  parameter logic [7:0]  TAP_INDEX   = 8'd1,
  parameter logic [15:0] LOAD_BASE   = 16'h0400,
  parameter logic [15:0] RAM_TOP     = 16'h7FFF,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        ce_in,
  output logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        load_active,
  output logic        load_done,
  output logic [15:0] load_len,
  output logic        overflow,
  output logic        overrun
`ifdef TAP_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_LOAD, ST_WRITE, ST_FLUSH, ST_HOLD
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state;
  logic [15:0] held_addr;
  logic [7:0]  held_byte;
  logic        held_ok;
  logic [15:0] hold_cnt;

  logic        tap_start;
  logic [16:0] tgt;
  logic        tgt_ok;

  assign tap_start = ioctl_download && (ioctl_index == TAP_INDEX);

  // 17-bit sum so a target past 16'hFFFF is caught instead of wrapping into low RAM.
  assign tgt    = {1'b0, LOAD_BASE} + {1'b0, ioctl_addr[15:0]};
  assign tgt_ok = (ioctl_addr[26:16] == '0) && (tgt <= {1'b0, RAM_TOP});

  assign load_active = (state != ST_IDLE);

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      held_addr <= '0;
      held_byte <= '0;
      held_ok   <= 1'b0;
      hold_cnt  <= '0;
      load_done <= 1'b0;
      load_len  <= '0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
`ifdef TAP_LOAD_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      case (state)
        ST_IDLE: if (tap_start) state <= ST_ARM;
        ST_ARM: begin
          load_len <= '0;
          overflow <= 1'b0;
          overrun  <= ioctl_wr;
`ifdef TAP_LOAD_CHECKSUM_EN
          checksum <= '0;
`endif
          state    <= ST_LOAD;
        end
        ST_LOAD: begin
          if (ioctl_wr) begin
            held_addr <= tgt[15:0];
            held_byte <= ioctl_dout;
            held_ok   <= tgt_ok;
            state     <= ST_WRITE;
          end else if (!ioctl_download) begin
            hold_cnt <= HOLD_LAST;
            state    <= ST_HOLD;
          end
        end
        ST_WRITE: begin
          if (!held_ok)               overflow <= 1'b1;
          if (load_len != 16'hFFFF)   load_len <= load_len + 16'd1;
          if (ioctl_wr)               overrun  <= 1'b1;
`ifdef TAP_LOAD_CHECKSUM_EN
          checksum <= checksum + held_byte;
`endif
          state <= ioctl_download ? ST_LOAD : ST_FLUSH;
        end
        ST_FLUSH: begin
          hold_cnt <= HOLD_LAST;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          // A fresh matching download restarts the load and drops the pending done pulse.
          if (tap_start) begin
            state <= ST_ARM;
          end else if (hold_cnt == '0) begin
            load_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    cpu_ce     = 1'b0;
    ioctl_wait = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = held_addr;
    ram_din    = held_byte;
    case (state)
      ST_IDLE: begin
        // The CPU pass-through is gated by reset_n so the bus is quiet while reset is held.
        if (reset_n) begin
          cpu_ce   = ce_in;
          ram_addr = cpu_addr;
          ram_din  = cpu_dout;
          ram_we   = cpu_we & ce_in;
        end
      end
      ST_ARM:   ioctl_wait = 1'b1;
      ST_WRITE: begin
        ioctl_wait = 1'b1;
        ram_we     = held_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tap_load_arbiter.sv
// tb_tap_load_arbiter: scoreboard bench for tap_load_arbiter; RAM writes are matched
// against a queue of expected (address, data) pairs filled as stimulus is driven.
module tb_tap_load_arbiter;

  localparam logic [15:0] LOAD_BASE = 16'h0400;
  localparam logic [15:0] RAM_TOP   = 16'h7FFF;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr, ioctl_wait;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [26:0] ioctl_addr;
  logic        ce_in, cpu_ce, cpu_we;
  logic [15:0] cpu_addr, ram_addr, load_len;
  logic [7:0]  cpu_dout, ram_din;
  logic        ram_we, load_active, load_done, overflow, overrun;
`ifdef TAP_LOAD_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  always #5 clk_sys = ~clk_sys;

  tap_load_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .ce_in(ce_in), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .load_active(load_active), .load_done(load_done), .load_len(load_len),
    .overflow(overflow), .overrun(overrun)
`ifdef TAP_LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Every RAM write seen on the falling edge must match the head of the scoreboard.
  always @(negedge clk_sys) begin
    if (reset_n && ram_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ram_write unexpected: addr=%h data=%h, none expected", ram_addr, ram_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ram_addr !== e.a || ram_din !== e.d) begin
          bad++;
          $display("FAIL ram_write: got addr=%h data=%h, want addr=%h data=%h",
                   ram_addr, ram_din, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drives one loader byte from LOAD; returns one cycle after the WRITE state.
  task automatic send(input logic [26:0] off, input logic [7:0] d);
    logic [16:0] tgt;
    logic        ok;
    tgt = 17'(LOAD_BASE) + 17'(off[15:0]);
    ok  = (off[26:16] == 11'd0) && (tgt <= 17'(RAM_TOP));
    ioctl_wr   = 1'b1;
    ioctl_addr = off;
    ioctl_dout = d;
    if (ok) exp_q.push_back('{a: tgt[15:0], d: d});
    tick();
    ioctl_wr = 1'b0;
    #1;
    total++;
    if (ram_we !== ok || ioctl_wait !== 1'b1) begin
      bad++;
      $display("FAIL send_write off=%h: ram_we=%b ioctl_wait=%b, want ram_we=%b ioctl_wait=1",
               off, ram_we, ioctl_wait, ok);
    end
    tick();
  endtask

  task automatic start_load();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    tick();
    tick();
  endtask

  // Call right after the edge that entered HOLD; expects load_done after exp_n cycles.
  task automatic wait_done(input int exp_n);
    int n    = 0;
    bit seen = 1'b0;
    while (n < 200 && !seen) begin
      tick();
      n++;
      #1;
      seen = load_done;
    end
    total++;
    if (!seen || n != exp_n) begin
      bad++;
      $display("FAIL done_timing: seen=%0b after %0d cycles, want pulse after %0d", seen, n, exp_n);
    end
    tick();
    total++;
    if (load_done !== 1'b0 || load_active !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: load_done=%b load_active=%b one cycle later, want 0 0",
               load_done, load_active);
    end
  endtask

  task automatic end_load();
    ioctl_download = 1'b0;
    tick();
    wait_done(16);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    ce_in = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hABCD; cpu_dout = 8'h5A;
    repeat (2) tick();
    #1;
    total++;
    if ({ioctl_wait, cpu_ce, ram_we, load_active, load_done, load_len, overflow, overrun,
         ram_addr, ram_din} !== 47'd0) begin
      bad++;
      $display("FAIL reset_outputs: cpu_ce=%b ram_we=%b ram_addr=%h ram_din=%h, want all 0",
               cpu_ce, ram_we, ram_addr, ram_din);
    end
`ifdef TAP_LOAD_CHECKSUM_EN
    total++;
    if (checksum !== 8'h00) begin
      bad++;
      $display("FAIL reset_checksum: got %h want 00", checksum);
    end
`endif
    cpu_we  = 1'b0;
    reset_n = 1'b1;
    #1;
    total++;
    if (cpu_ce !== 1'b1 || ram_addr !== 16'hABCD) begin
      bad++;
      $display("FAIL reset_release: cpu_ce=%b ram_addr=%h, want 1 abcd", cpu_ce, ram_addr);
    end
    ce_in = 1'b0;
    #1;
    total++;
    if (cpu_ce !== 1'b0) begin
      bad++;
      $display("FAIL reset_follow: cpu_ce=%b want 0", cpu_ce);
    end
    // Reset asserted in the middle of a WRITE cycle.
    start_load();
    ioctl_wr = 1'b1; ioctl_addr = 27'd0; ioctl_dout = 8'h11;
    tick();
    ioctl_wr = 1'b0;
    #1;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 16'h0400) begin
      bad++;
      $display("FAIL reset_prewrite: ram_we=%b ram_addr=%h, want 1 0400", ram_we, ram_addr);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({ioctl_wait, cpu_ce, ram_we, load_active, load_done, load_len, overflow, overrun,
         ram_addr, ram_din} !== 47'd0) begin
      bad++;
      $display("FAIL reset_midwrite: ram_we=%b load_active=%b load_len=%h, want all 0",
               ram_we, load_active, load_len);
    end
    ioctl_download = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_index_filter();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd2;
    for (int i = 0; i < 8; i++) begin
      ce_in      = i[0];
      ioctl_wr   = (i == 3);
      ioctl_addr = 27'd0;
      ioctl_dout = 8'hEE;
      #1;
      total++;
      if (cpu_ce !== ce_in || load_active !== 1'b0 || ioctl_wait !== 1'b0) begin
        bad++;
        $display("FAIL index_filter cycle %0d: cpu_ce=%b load_active=%b ioctl_wait=%b, want %b 0 0",
                 i, cpu_ce, load_active, ioctl_wait, ce_in);
      end
      tick();
    end
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ce_in = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    ce_in = 1'b1;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    #1;
    total++;
    if (cpu_ce !== 1'b1) begin
      bad++;
      $display("FAIL basic_idle_ce: cpu_ce=%b want 1", cpu_ce);
    end
    tick();
    #1;
    total++;
    if (ioctl_wait !== 1'b1 || cpu_ce !== 1'b0 || load_active !== 1'b1) begin
      bad++;
      $display("FAIL basic_arm: ioctl_wait=%b cpu_ce=%b load_active=%b, want 1 0 1",
               ioctl_wait, cpu_ce, load_active);
    end
    tick();
    #1;
    total++;
    if (ioctl_wait !== 1'b0 || load_len !== 16'd0 || cpu_ce !== 1'b0) begin
      bad++;
      $display("FAIL basic_load: ioctl_wait=%b load_len=%0d cpu_ce=%b, want 0 0 0",
               ioctl_wait, load_len, cpu_ce);
    end
    send(27'd0, 8'hA5);
    send(27'd1, 8'h5A);
    send(27'd2, 8'hFF);
    #1;
    total++;
    if (load_len !== 16'd3 || overflow !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL basic_len: load_len=%0d overflow=%b overrun=%b, want 3 0 0",
               load_len, overflow, overrun);
    end
    end_load();
    total++;
    if (cpu_ce !== 1'b1) begin
      bad++;
      $display("FAIL basic_release: cpu_ce=%b want 1", cpu_ce);
    end
`ifdef TAP_LOAD_CHECKSUM_EN
    total++;
    if (checksum !== 8'hFE) begin
      bad++;
      $display("FAIL basic_checksum: got %h want fe", checksum);
    end
`endif
    ce_in = 1'b0;
  endtask

  task automatic test_range();
    start_load();
    send(27'h0007BFF, 8'h3C);
    send(27'h0007C00, 8'hC3);
    #1;
    total++;
    if (overflow !== 1'b1 || load_len !== 16'd2) begin
      bad++;
      $display("FAIL range_top: overflow=%b load_len=%0d, want 1 2", overflow, load_len);
    end
    send(27'h0010000, 8'h01);
    #1;
    total++;
    if (load_len !== 16'd3) begin
      bad++;
      $display("FAIL range_high_bits: load_len=%0d want 3", load_len);
    end
    end_load();
`ifdef TAP_LOAD_CHECKSUM_EN
    total++;
    if (checksum !== 8'h00) begin
      bad++;
      $display("FAIL range_checksum: got %h want 00", checksum);
    end
`endif
  endtask

  task automatic test_back_pressure();
    start_load();
    #1;
    total++;
    if (overflow !== 1'b0 || load_len !== 16'd0) begin
      bad++;
      $display("FAIL bp_arm_clear: overflow=%b load_len=%0d, want 0 0", overflow, load_len);
    end
    ioctl_wr = 1'b1; ioctl_addr = 27'd0; ioctl_dout = 8'h11;
    exp_q.push_back('{a: 16'h0400, d: 8'h11});
    tick();
    ioctl_addr = 27'd1; ioctl_dout = 8'h22;
    #1;
    total++;
    if (ioctl_wait !== 1'b1 || ram_we !== 1'b1) begin
      bad++;
      $display("FAIL bp_wait: ioctl_wait=%b ram_we=%b, want 1 1", ioctl_wait, ram_we);
    end
    tick();
    ioctl_wr = 1'b0;
    #1;
    total++;
    if (overrun !== 1'b1 || load_len !== 16'd1) begin
      bad++;
      $display("FAIL bp_overrun: overrun=%b load_len=%0d, want 1 1", overrun, load_len);
    end
    send(27'd2, 8'h33);
    #1;
    total++;
    if (load_len !== 16'd2) begin
      bad++;
      $display("FAIL bp_len: load_len=%0d want 2", load_len);
    end
    end_load();
`ifdef TAP_LOAD_CHECKSUM_EN
    total++;
    if (checksum !== 8'h44) begin
      bad++;
      $display("FAIL bp_checksum: got %h want 44", checksum);
    end
`endif
  endtask

  task automatic test_edge_timing();
    // CPU write in the same cycle the download starts must still land.
    ce_in = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_dout = 8'h9C;
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    exp_q.push_back('{a: 16'h1234, d: 8'h9C});
    #1;
    total++;
    if (cpu_ce !== 1'b1 || ram_we !== 1'b1) begin
      bad++;
      $display("FAIL edge_cpu_commit: cpu_ce=%b ram_we=%b, want 1 1", cpu_ce, ram_we);
    end
    tick();
    #1;
    total++;
    if (cpu_ce !== 1'b0 || ram_we !== 1'b0 || ioctl_wait !== 1'b1) begin
      bad++;
      $display("FAIL edge_gate: cpu_ce=%b ram_we=%b ioctl_wait=%b, want 0 0 1",
               cpu_ce, ram_we, ioctl_wait);
    end
    ce_in = 1'b0; cpu_we = 1'b0;
    ioctl_download = 1'b0;
    tick();
    tick();
    wait_done(16);

    // Last byte strobed in the same cycle the download falls.
    start_load();
    ioctl_download = 1'b0;
    send(27'd5, 8'h77);
    #1;
    total++;
    if (ioctl_wait !== 1'b0 || load_active !== 1'b1 || load_len !== 16'd1) begin
      bad++;
      $display("FAIL edge_flush: ioctl_wait=%b load_active=%b load_len=%0d, want 0 1 1",
               ioctl_wait, load_active, load_len);
    end
    tick();
    repeat (3) tick();
    // Re-arm during HOLD: the earlier done pulse must never appear.
    ioctl_download = 1'b1;
    tick();
    #1;
    total++;
    if (ioctl_wait !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL edge_rearm: ioctl_wait=%b load_done=%b, want 1 0", ioctl_wait, load_done);
    end
    ioctl_download = 1'b0;
    tick();
    tick();
    wait_done(16);
  endtask

  initial begin
    test_reset();
    test_index_filter();
    test_basic_load();
    test_range();
    test_back_pressure();
    test_edge_timing();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected writes never seen, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
